// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter.
// On an accepted start, the pattern is sent MSB first, one bit per clock.
// The pattern is repeated repeat_n times, with gap_len idle cycles between repetitions.
// The pattern, repeat count and gap length are shadowed at start,
// so changes to the inputs during a transfer do not affect it.
// All outputs are registered and change only on a clock edge or on reset.
module seq_pattern_gen #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap_len,
    output logic             data_out,
    output logic             data_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q,       state_d;
    logic [WIDTH-1:0] pattern_q,     pattern_d;      // shadowed pattern
    logic [CNT_W-1:0] reps_q,        reps_d;         // repetitions left, including current one
    logic [GAP_W-1:0] gap_len_q,     gap_len_d;      // shadowed gap length
    logic [GAP_W-1:0] gap_cnt_q,     gap_cnt_d;      // idle cycles left in current gap
    logic [BIT_W-1:0] bit_idx_q,     bit_idx_d;      // index of the bit now on data_out
    logic             data_out_q,    data_out_d;
    logic             data_valid_q,  data_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q,        busy_d;
    logic             done_q,        done_d;

    // Next-state and next-output logic.
    // The outputs are computed for the cycle that follows the edge.
    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        reps_d        = reps_q;
        gap_len_d     = gap_len_q;
        gap_cnt_d     = gap_cnt_q;
        bit_idx_d     = bit_idx_q;
        data_out_d    = 1'b0;
        data_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                // A zero repeat count would describe an empty transfer, so it is dropped.
                if (start && (repeat_n != '0)) begin
                    state_d       = SHIFT;
                    pattern_d     = pattern;
                    reps_d        = repeat_n;
                    gap_len_d     = gap_len;
                    bit_idx_d     = MSB_IDX;
                    data_out_d    = pattern[WIDTH-1];
                    data_valid_d  = 1'b1;
                    frame_start_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    reps_d  = '0;
                end else if (bit_idx_q != '0) begin
                    bit_idx_d    = bit_idx_q - BIT_W'(1);
                    data_out_d   = pattern_q[bit_idx_d];
                    data_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end else if (reps_q > CNT_W'(1)) begin
                    reps_d = reps_q - CNT_W'(1);
                    busy_d = 1'b1;
                    if (gap_len_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len_q;
                    end else begin
                        // With no gap, the next MSB follows bit 0 directly.
                        bit_idx_d     = MSB_IDX;
                        data_out_d    = pattern_q[WIDTH-1];
                        data_valid_d  = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    reps_d  = '0;
                    done_d  = 1'b1;
                end
            end

            GAP: begin
                if (abort) begin
                    state_d   = IDLE;
                    reps_d    = '0;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d       = SHIFT;
                    gap_cnt_d     = '0;
                    bit_idx_d     = MSB_IDX;
                    data_out_d    = pattern_q[WIDTH-1];
                    data_valid_d  = 1'b1;
                    frame_start_d = 1'b1;
                    busy_d        = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    busy_d    = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shadow and output registers.
    // Reset clears these registers asynchronously, which drops any transfer in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pattern_q     <= '0;
            reps_q        <= '0;
            gap_len_q     <= '0;
            gap_cnt_q     <= '0;
            bit_idx_q     <= '0;
            data_out_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            reps_q        <= reps_d;
            gap_len_q     <= gap_len_d;
            gap_cnt_q     <= gap_cnt_d;
            bit_idx_q     <= bit_idx_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen.
// On each accepted start, the stimulus side expands the transfer into the
// expected per-cycle output trace: bits, gaps, then the done cycle.
// That trace is pushed to a queue. A separate monitor pops one entry
// per cycle and compares it with the DUT. An empty queue means all outputs are 0.
module tb_seq_pattern_gen;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_n = '0;
    logic [GAP_W-1:0] gap_len = '0;
    logic             data_out, data_valid, frame_start, busy, done;

    seq_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .pattern(pattern), .repeat_n(repeat_n), .gap_len(gap_len),
        .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Observation tuple: {data_out, data_valid, frame_start, busy, done}
    typedef logic [4:0] obs_t;
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   model_busy = 1'b0;   // expected busy in the current cycle

    // Expected trace for one transfer, taken directly from the framing rules.
    function automatic void push_transfer(logic [WIDTH-1:0] pat, int reps, int gap);
        for (int r = 0; r < reps; r++) begin
            for (int b = WIDTH - 1; b >= 0; b--)
                exp_q.push_back({pat[b], 1'b1, (b == WIDTH - 1), 1'b1, 1'b0});
            if (r < reps - 1)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00001);
    endfunction

    // Monitor: compare one expected tuple against the DUT every cycle.
    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'b00000;
        a = {data_out, data_valid, frame_start, busy, done};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL outputs t=%0t actual{dout,vld,fs,busy,done}=%b required=%b", $time, a, e);
        model_busy = e[1];
    end

    // One clock edge: the model reacts to the inputs that the DUT samples at this edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            if (abort && model_busy) begin
                exp_q.delete();
                $display("abort t=%0t", $time);
            end
            if (!model_busy && start && (repeat_n != '0)) begin
                push_transfer(pattern, int'(repeat_n), int'(gap_len));
                $display("xfer t=%0t pattern=%b repeat_n=%0d gap_len=%0d", $time, pattern, repeat_n, gap_len);
            end
        end
        #1;
    endtask

    task automatic drive(bit st, bit ab, logic [WIDTH-1:0] pat, int rn, int gl);
        start    = st;
        abort    = ab;
        pattern  = pat;
        repeat_n = CNT_W'(rn);
        gap_len  = GAP_W'(gl);
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    initial begin
        // Power-on reset.
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        // Single repetition.
        drive(1, 0, 4'b1101, 1, 0); idle(6);
        // Three repetitions, back to back.
        drive(1, 0, 4'b1101, 3, 0); idle(14);
        // Two repetitions separated by a 3-cycle gap.
        drive(1, 0, 4'b1011, 2, 3); idle(13);
        // A zero repeat count is ignored; the next start works normally.
        drive(1, 0, 4'b1111, 0, 2); idle(10);
        drive(1, 0, 4'b1101, 1, 0); idle(6);

        // Start while busy is ignored; abort mid-stream; restart afterwards.
        drive(1, 0, 4'b1101, 2, 0);   // cycle 0
        idle(1);                      // cycle 1
        drive(1, 0, 4'b0000, 1, 0);   // cycle 2
        idle(3);                      // cycles 3-5
        drive(0, 1, 4'b0000, 1, 0);   // cycle 6
        idle(2);                      // cycles 7-8
        drive(1, 0, 4'b1101, 1, 0);   // cycle 9
        idle(8);

        // Asynchronous reset during a gap; the transfer produces no done.
        drive(1, 0, 4'b1011, 3, 5);
        idle(6);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({data_out, data_valid, frame_start, busy, done} === 5'b00000) n_pass++;
        else $display("FAIL async_reset actual=%b required=00000",
                      {data_out, data_valid, frame_start, busy, done});
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        drive(1, 0, 4'b1101, 1, 0); idle(6);

        // Maximum repeat count, with a 1-cycle gap.
        drive(1, 0, 4'b1001, 255, 1); idle(1290);

        // Random stimulus: starts, aborts and input changes while busy.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            abort    = ($urandom_range(0, 39) == 0);
            pattern  = WIDTH'($urandom);
            repeat_n = CNT_W'($urandom_range(0, 3));
            gap_len  = GAP_W'($urandom_range(0, 3));
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat_n = CNT_W'(1);
        idle(60);

        // Every expected output must have been observed.
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain leftover_expected=%0d required=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
